// File: rtl/ram_nr1w_dbg_if.sv
// ram_nr1w_dbg_if: bundle of the kernel and debug ports of ram_nr1w_dbg.
//
// Signals (master = kernel/bench side, slave = RAM side):
//   raddr            NREAD packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rdata            NREAD packed read data, port i at [i*WIDTH +: WIDTH]
//   waddr/wdata/wen  kernel write port
//   debug_write_*    debug write port
//   debug_addr/data  debug read port
//   ready            memory accepts kernel traffic
//   oob_err          sticky out-of-range access flag
//   state_dbg        controller state (0 = CLEAR, 1 = RUN)
//
// Handshake: there is no per-transfer valid/ready pair. Every port is sampled on
// every rising edge; wen/debug_write_en act as write valids that are always
// accepted in RUN, and ready is a registered status flag telling the kernel
// that the post-reset clear sweep is complete and traffic is being honoured.
interface ram_nr1w_dbg_if #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NREAD      = 2
);
   logic [NREAD*ADDR_WIDTH-1:0] raddr;
   logic [NREAD*WIDTH-1:0]      rdata;
   logic [ADDR_WIDTH-1:0]       waddr;
   logic [WIDTH-1:0]            wdata;
   logic                        wen;
   logic [ADDR_WIDTH-1:0]       debug_write_addr;
   logic [WIDTH-1:0]            debug_write_data;
   logic                        debug_write_en;
   logic [ADDR_WIDTH-1:0]       debug_addr;
   logic [WIDTH-1:0]            debug_data;
   logic                        ready;
   logic                        oob_err;
   logic                        state_dbg;

   modport master (
      output raddr, waddr, wdata, wen,
      output debug_write_addr, debug_write_data, debug_write_en, debug_addr,
      input  rdata, debug_data, ready, oob_err, state_dbg
   );

   modport slave (
      input  raddr, waddr, wdata, wen,
      input  debug_write_addr, debug_write_data, debug_write_en, debug_addr,
      output rdata, debug_data, ready, oob_err, state_dbg
   );
endinterface

// File: rtl/ram_nr1w_dbg.sv
// ram_nr1w_dbg: NREAD-read / 1-write synchronous RAM with a debug read/write
// port and an optional zeroing sweep after reset release.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (outputs zero, memory contents kept)
//   bus  ram_nr1w_dbg_if slave modport (kernel ports, debug ports, status)
module ram_nr1w_dbg #(
   parameter int WIDTH          = 32,
   parameter int DEPTH          = 16,
   parameter int ADDR_WIDTH     = 5,
   parameter int NREAD          = 2,
   parameter bit READ_FIRST     = 1'b0,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   ram_nr1w_dbg_if.slave bus
);
   // The array spans the whole address space so any address indexes it
   // directly; words >= DEPTH are never written or read and trim away.
   localparam int                    MEM_WORDS = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

   typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;
   localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   clr_ptr_q, clr_ptr_d;
   logic                    ready_q, ready_d;
   logic                    oob_err_q, oob_err_d;
   logic [NREAD*WIDTH-1:0]  rdata_q, rdata_d;
   logic [WIDTH-1:0]        debug_data_q, debug_data_d;

   logic [WIDTH-1:0]        mem [MEM_WORDS];

   // Effective write ports after state gating and range checks.
   logic                    kw_en, dw_en;
   logic [ADDR_WIDTH-1:0]   kw_addr, dw_addr;
   logic [WIDTH-1:0]        kw_data, dw_data;

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
      return {1'b0, a} < DEPTH_EXT;
   endfunction

   // Word seen by a read sampled this edge; in write-first mode the winning
   // write of the same edge is forwarded (debug beats kernel).
   function automatic logic [WIDTH-1:0] fwd_read(input logic [ADDR_WIDTH-1:0] a);
      logic [WIDTH-1:0] v;
      v = mem[a];
      if (!READ_FIRST) begin
         if (dw_en && (dw_addr == a)) begin
            v = dw_data;
         end else if (kw_en && (kw_addr == a)) begin
            v = kw_data;
         end
      end
      return v;
   endfunction

   // Write port selection. The kernel port doubles as the clear port.
   always_comb begin
      kw_en   = 1'b0;
      kw_addr = bus.waddr;
      kw_data = bus.wdata;
      dw_en   = 1'b0;
      dw_addr = bus.debug_write_addr;
      dw_data = bus.debug_write_data;
      if (rst) begin
         // Bench preload path: only debug writes land while held in reset.
         dw_en = bus.debug_write_en && in_range(bus.debug_write_addr);
      end else if (state_q == ST_CLEAR) begin
         kw_en   = 1'b1;
         kw_addr = clr_ptr_q;
         kw_data = '0;
      end else begin
         dw_en = bus.debug_write_en && in_range(bus.debug_write_addr);
         kw_en = bus.wen && in_range(bus.waddr) &&
                 !(dw_en && (bus.debug_write_addr == bus.waddr));
      end
   end

   always_ff @(posedge clk) begin
      if (kw_en) begin
         mem[kw_addr] <= kw_data;
      end
      if (dw_en) begin
         mem[dw_addr] <= dw_data;
      end
   end

   // Controller: CLEAR sweeps every word to zero once, RUN is terminal.
   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      ready_d   = (state_q == ST_RUN);
      if (state_q == ST_CLEAR) begin
         clr_ptr_d = clr_ptr_q + 1'b1;
         if (clr_ptr_q == LAST_ADDR) begin
            state_d   = ST_RUN;
            clr_ptr_d = '0;
         end
      end
   end

   // Read ports and sticky out-of-range flag.
   always_comb begin
      rdata_d      = '0;
      debug_data_d = '0;
      oob_err_d    = oob_err_q;
      if (state_q == ST_RUN) begin
         for (int i = 0; i < NREAD; i++) begin
            if (in_range(bus.raddr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
               rdata_d[i*WIDTH +: WIDTH] = fwd_read(bus.raddr[i*ADDR_WIDTH +: ADDR_WIDTH]);
            end else begin
               oob_err_d = 1'b1;
            end
         end
         if (in_range(bus.debug_addr)) begin
            debug_data_d = fwd_read(bus.debug_addr);
         end
      end
      if (bus.wen && !in_range(bus.waddr)) begin
         oob_err_d = 1'b1;
      end
      if (bus.debug_write_en && !in_range(bus.debug_write_addr)) begin
         oob_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= RESET_STATE;
         clr_ptr_q    <= '0;
         ready_q      <= 1'b0;
         oob_err_q    <= 1'b0;
         rdata_q      <= '0;
         debug_data_q <= '0;
      end else begin
         state_q      <= state_d;
         clr_ptr_q    <= clr_ptr_d;
         ready_q      <= ready_d;
         oob_err_q    <= oob_err_d;
         rdata_q      <= rdata_d;
         debug_data_q <= debug_data_d;
      end
   end

   assign bus.rdata      = rdata_q;
   assign bus.debug_data = debug_data_q;
   assign bus.ready      = ready_q;
   assign bus.oob_err    = oob_err_q;
   assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_ram_nr1w_dbg.sv
// tb_ram_nr1w_dbg: directed bench for ram_nr1w_dbg.
// dut_a: DEPTH=16, NREAD=4, write-first, clear sweep after reset.
// dut_b: DEPTH=12, NREAD=2, read-first, no clear sweep.
module tb_ram_nr1w_dbg;
   logic clk;
   logic rst_a;
   logic rst_b;
   int   checks = 0;
   int   errors = 0;

   ram_nr1w_dbg_if #(.WIDTH(32), .ADDR_WIDTH(5), .NREAD(4)) bus_a ();
   ram_nr1w_dbg_if #(.WIDTH(32), .ADDR_WIDTH(5), .NREAD(2)) bus_b ();

   ram_nr1w_dbg #(
      .WIDTH(32), .DEPTH(16), .ADDR_WIDTH(5), .NREAD(4),
      .READ_FIRST(1'b0), .CLEAR_ON_RESET(1'b1)
   ) dut_a (
      .clk (clk),
      .rst (rst_a),
      .bus (bus_a)
   );

   ram_nr1w_dbg #(
      .WIDTH(32), .DEPTH(12), .ADDR_WIDTH(5), .NREAD(2),
      .READ_FIRST(1'b1), .CLEAR_ON_RESET(1'b0)
   ) dut_b (
      .clk (clk),
      .rst (rst_b),
      .bus (bus_b)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      // Quiet inputs, both DUTs held in reset.
      rst_a = 1'b1;
      rst_b = 1'b1;
      bus_a.raddr = '0; bus_a.waddr = '0; bus_a.wdata = '0; bus_a.wen = 1'b0;
      bus_a.debug_write_addr = '0; bus_a.debug_write_data = '0;
      bus_a.debug_write_en = 1'b0; bus_a.debug_addr = '0;
      bus_b.raddr = '0; bus_b.waddr = '0; bus_b.wdata = '0; bus_b.wen = 1'b0;
      bus_b.debug_write_addr = '0; bus_b.debug_write_data = '0;
      bus_b.debug_write_en = 1'b0; bus_b.debug_addr = '0;
      tick();
      tick();

      // Reset values
      chk("a_rst_ready", {31'd0, bus_a.ready}, 32'd0);
      chk("a_rst_oob", {31'd0, bus_a.oob_err}, 32'd0);
      chk("a_rst_rdata0", bus_a.rdata[31:0], 32'd0);
      chk("a_rst_debug", bus_a.debug_data, 32'd0);
      chk("b_rst_ready", {31'd0, bus_b.ready}, 32'd0);
      chk("b_rst_rdata", bus_b.rdata[31:0], 32'd0);

      // Preload mem[i] = i+1, i = 0..9, through the debug port during reset.
      for (int i = 0; i < 10; i++) begin
         bus_a.debug_write_addr = 5'(i); bus_a.debug_write_data = 32'(i + 1);
         bus_a.debug_write_en   = 1'b1;
         bus_b.debug_write_addr = 5'(i); bus_b.debug_write_data = 32'(i + 1);
         bus_b.debug_write_en   = 1'b1;
         tick();
      end
      bus_a.debug_write_en = 1'b0;
      bus_b.debug_write_en = 1'b0;

      // ---- dut_b: no clear sweep, read-first ----
      rst_b = 1'b0;
      bus_b.debug_addr = 5'd3;
      bus_b.raddr = {5'd9, 5'd0};
      tick();
      chk("b_ready_first_edge", {31'd0, bus_b.ready}, 32'd1);
      chk("b_preload_debug3", bus_b.debug_data, 32'd4);
      chk("b_preload_r0", bus_b.rdata[31:0], 32'd1);
      chk("b_preload_r9", bus_b.rdata[63:32], 32'd10);

      // Collision on addr 7: debug write wins, read returns old word this edge.
      bus_b.waddr = 5'd7; bus_b.wdata = 32'd11; bus_b.wen = 1'b1;
      bus_b.debug_write_addr = 5'd7; bus_b.debug_write_data = 32'd22;
      bus_b.debug_write_en = 1'b1;
      bus_b.raddr = {5'd0, 5'd7};
      bus_b.debug_addr = 5'd7;
      tick();
      chk("b_coll_rdata_old", bus_b.rdata[31:0], 32'd8);
      chk("b_coll_debug_old", bus_b.debug_data, 32'd8);
      bus_b.wen = 1'b0; bus_b.debug_write_en = 1'b0;
      tick();
      chk("b_coll_after", bus_b.rdata[31:0], 32'd22);

      // Two writes to different addresses both commit.
      bus_b.waddr = 5'd2; bus_b.wdata = 32'h55; bus_b.wen = 1'b1;
      bus_b.debug_write_addr = 5'd4; bus_b.debug_write_data = 32'h66;
      bus_b.debug_write_en = 1'b1;
      tick();
      bus_b.wen = 1'b0; bus_b.debug_write_en = 1'b0;
      bus_b.raddr = {5'd4, 5'd2};
      tick();
      chk("b_dual_w2", bus_b.rdata[31:0], 32'h55);
      chk("b_dual_w4", bus_b.rdata[63:32], 32'h66);

      // Last valid word (DEPTH-1) is a normal word.
      bus_b.debug_write_addr = 5'd11; bus_b.debug_write_data = 32'hAB;
      bus_b.debug_write_en = 1'b1;
      tick();
      bus_b.debug_write_en = 1'b0;
      bus_b.debug_addr = 5'd11;
      tick();
      chk("b_last_word", bus_b.debug_data, 32'hAB);
      chk("b_oob_clean", {31'd0, bus_b.oob_err}, 32'd0);

      // Out-of-range write: dropped, flag set and sticky.
      bus_b.raddr = {5'd5, 5'd1};
      bus_b.waddr = 5'd13; bus_b.wdata = 32'd99; bus_b.wen = 1'b1;
      tick();
      bus_b.wen = 1'b0;
      chk("b_oob_wr_flag", {31'd0, bus_b.oob_err}, 32'd1);
      tick();
      chk("b_oob_w1_kept", bus_b.rdata[31:0], 32'd2);
      chk("b_oob_w5_kept", bus_b.rdata[63:32], 32'd6);
      bus_b.raddr = {5'd14, 5'd1};
      tick();
      chk("b_oob_rd14", bus_b.rdata[63:32], 32'd0);
      chk("b_oob_sticky", {31'd0, bus_b.oob_err}, 32'd1);

      // Reset clears outputs at once; memory survives; read at DEPTH flags oob.
      bus_b.raddr = {5'd0, 5'd0};
      rst_b = 1'b1;
      #1;
      chk("b_async_oob", {31'd0, bus_b.oob_err}, 32'd0);
      chk("b_async_ready", {31'd0, bus_b.ready}, 32'd0);
      chk("b_async_debug", bus_b.debug_data, 32'd0);
      tick();
      rst_b = 1'b0;
      bus_b.raddr = {5'd0, 5'd12};
      bus_b.debug_addr = 5'd7;
      tick();
      chk("b_rd12_zero", bus_b.rdata[31:0], 32'd0);
      chk("b_rd12_oob", {31'd0, bus_b.oob_err}, 32'd1);
      chk("b_mem_kept", bus_b.debug_data, 32'd22);

      // ---- dut_a: clear sweep, write-first, 4 read ports ----
      rst_a = 1'b0;
      bus_a.raddr = {5'd4, 5'd3, 5'd2, 5'd1};
      bus_a.waddr = 5'd3; bus_a.wdata = 32'h77; bus_a.wen = 1'b1;
      bus_a.debug_write_addr = 5'd4; bus_a.debug_write_data = 32'h88;
      bus_a.debug_write_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         chk($sformatf("a_clear_ready_%0d", i), {31'd0, bus_a.ready}, 32'd0);
         chk($sformatf("a_clear_rd_%0d", i), bus_a.rdata[31:0], 32'd0);
      end
      bus_a.wen = 1'b0; bus_a.debug_write_en = 1'b0;
      tick();
      chk("a_ready_after_sweep", {31'd0, bus_a.ready}, 32'd1);
      for (int r = 0; r < 4; r++) begin
         bus_a.raddr = {5'(4*r+3), 5'(4*r+2), 5'(4*r+1), 5'(4*r)};
         tick();
         for (int p = 0; p < 4; p++) begin
            chk($sformatf("a_zero_%0d", 4*r+p), bus_a.rdata[p*32 +: 32], 32'd0);
         end
      end

      // Multi-port read: mem[k] = 3k.
      for (int k = 0; k < 16; k++) begin
         bus_a.debug_write_addr = 5'(k); bus_a.debug_write_data = 32'(3*k);
         bus_a.debug_write_en = 1'b1;
         tick();
      end
      bus_a.debug_write_en = 1'b0;
      bus_a.raddr = {5'd15, 5'd5, 5'd2, 5'd1};
      tick();
      chk("a_mp_p0", bus_a.rdata[31:0], 32'd3);
      chk("a_mp_p1", bus_a.rdata[63:32], 32'd6);
      chk("a_mp_p2", bus_a.rdata[95:64], 32'd15);
      chk("a_mp_p3", bus_a.rdata[127:96], 32'd45);

      // Collision in write-first mode: winning debug data forwarded.
      bus_a.waddr = 5'd7; bus_a.wdata = 32'd11; bus_a.wen = 1'b1;
      bus_a.debug_write_addr = 5'd7; bus_a.debug_write_data = 32'd22;
      bus_a.debug_write_en = 1'b1;
      bus_a.raddr = {5'd0, 5'd0, 5'd9, 5'd7};
      bus_a.debug_addr = 5'd7;
      tick();
      chk("a_coll_rdata_new", bus_a.rdata[31:0], 32'd22);
      chk("a_coll_debug_new", bus_a.debug_data, 32'd22);
      chk("a_coll_r9", bus_a.rdata[63:32], 32'd27);
      // Kernel-only write forwarded too.
      bus_a.debug_write_en = 1'b0;
      bus_a.waddr = 5'd9; bus_a.wdata = 32'h99;
      tick();
      bus_a.wen = 1'b0;
      chk("a_fwd_kernel", bus_a.rdata[63:32], 32'h99);
      chk("a_mem7", bus_a.rdata[31:0], 32'd22);

      // Out-of-range debug write flags oob.
      chk("a_oob_clean", {31'd0, bus_a.oob_err}, 32'd0);
      bus_a.debug_write_addr = 5'd20; bus_a.debug_write_data = 32'd5;
      bus_a.debug_write_en = 1'b1;
      tick();
      bus_a.debug_write_en = 1'b0;
      chk("a_oob_dbgwr", {31'd0, bus_a.oob_err}, 32'd1);

      // Reset mid-clear: sweep restarts and runs the full 16 cycles.
      bus_a.raddr = {5'd0, 5'd0, 5'd0, 5'd15};
      bus_a.debug_addr = 5'd15;
      rst_a = 1'b1;
      #1;
      chk("a_async_ready", {31'd0, bus_a.ready}, 32'd0);
      chk("a_async_rdata", bus_a.rdata[31:0], 32'd0);
      tick();
      rst_a = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("a_midclr_ready", {31'd0, bus_a.ready}, 32'd0);
      rst_a = 1'b1;
      #1;
      chk("a_midclr_rdata", bus_a.rdata[31:0], 32'd0);
      chk("a_midclr_oob", {31'd0, bus_a.oob_err}, 32'd0);
      tick();
      rst_a = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tick();
         chk($sformatf("a_resweep_ready_%0d", i), {31'd0, bus_a.ready}, 32'd0);
      end
      tick();
      chk("a_resweep_done", {31'd0, bus_a.ready}, 32'd1);
      chk("a_resweep_w15", bus_a.debug_data, 32'd0);
      chk("a_resweep_r15", bus_a.rdata[31:0], 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ram_nr1w_dbg.md
# ram_nr1w_dbg

Parametrised multi-read-port, single-write-port synchronous RAM with a debug read/write port and an optional post-reset clear sweep. Successor to the fixed two-read-port, 16-entry RAM used by the HLS kernel benches: width, depth and read-port count are generics, same-address read/write behaviour is selectable, and out-of-range accesses are flagged. It sits beside generated kernels, serving their `raddr_N`/`waddr_0` ports while the bench preloads and inspects memory through the debug port.

## Interface
- `WIDTH`, 32, data width in bits
- `DEPTH`, 16, number of words (1..2**ADDR_WIDTH)
- `ADDR_WIDTH`, 5, address width
- `NREAD`, 2, number of kernel read ports (1..8)
- `READ_FIRST`, 0, 1: same-cycle read of a written address returns old data; 0: returns new data
- `CLEAR_ON_RESET`, 1, 1: zero every word after reset release before accepting traffic

- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: asynchronous, active-high reset
- `raddr` in NREAD*ADDR_WIDTH: read addresses, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- `rdata` out NREAD*WIDTH: read data, port i at bits [i*WIDTH +: WIDTH]
- `waddr` in ADDR_WIDTH: kernel write address
- `wdata` in WIDTH: kernel write data
- `wen` in 1: kernel write enable
- `debug_write_addr` in ADDR_WIDTH, `debug_write_data` in WIDTH, `debug_write_en` in 1: debug write port
- `debug_addr` in ADDR_WIDTH: debug read address
- `debug_data` out WIDTH: debug read data
- `ready` out 1: high when memory accepts kernel traffic
- `oob_err` out 1: sticky, set by any enabled access with address >= DEPTH

## Operation
- States: CLEAR, RUN. Reset forces CLEAR with `clr_ptr`=0 when CLEAR_ON_RESET=1, otherwise RUN.
- While `rst` high: memory array is not reset; `debug_write_en` writes are honoured (bench preload); `wen` ignored.
- CLEAR: writes 0 to word `clr_ptr` each cycle, `clr_ptr` increments; at `clr_ptr`==DEPTH-1 the zero is written and state moves to RUN. Takes exactly DEPTH cycles. During CLEAR, `wen` and `debug_write_en` are ignored; all reads return 0.
- RUN: terminal until reset.
- Writes in RUN: `wen` writes `wdata` to `waddr`; `debug_write_en` writes `debug_write_data`. Both enabled to the same address in the same cycle: debug write wins. Different addresses: both commit.
- Reads: every read port and the debug port register `mem[addr]` on each edge (always enabled).
- Same-cycle read/write collision: READ_FIRST=1 returns pre-write word; READ_FIRST=0 returns the winning write data.
- Out-of-range (addr >= DEPTH): writes dropped, reads return 0, `oob_err` set (read ports in RUN only; writes whenever enabled). Cleared only by `rst`.
- No arithmetic on data; address compare is unsigned ADDR_WIDTH bits.

## Timing
- Reset values: `rdata`=0, `debug_data`=0, `ready`=0, `oob_err`=0, `clr_ptr`=0.
- `ready` is registered: rises the cycle after the last clear write (CLEAR_ON_RESET=1: DEPTH+1 edges after `rst` falls; CLEAR_ON_RESET=0: first edge after `rst` falls).
- Read latency 1 cycle for all read ports and the debug port: address sampled at edge k, data valid after edge k; held until next edge.
- Write latency: committed at edge k, visible to a read sampled at edge k+1 (or at edge k if READ_FIRST=0).
- `rst` asserted mid-CLEAR or mid-RUN: outputs zero immediately, sweep restarts from 0 after release.

## Test plan
- Preload: while `rst`=1, debug-write mem[i]=i+1 for i=0..9, CLEAR_ON_RESET=0; release; `debug_addr`=3 -> `debug_data`=4 one cycle later, `ready`=1 first edge after release.
- Clear sweep: DEPTH=16, CLEAR_ON_RESET=1, preload as above; `ready` low for 16 cycles after release; then every `raddr` 0..15 reads 0; `wen` during CLEAR has no effect.
- Multi-port read: NREAD=4, mem[k]=k*3; raddr ports =1,2,5,15 -> `rdata`=3,6,15,45 next cycle.
- Collision: `wen`/`debug_write_en` both to addr 7 with 11/22 -> mem[7]=22; read of 7 same cycle returns old value with READ_FIRST=1, 22 with READ_FIRST=0.
- Out-of-range: DEPTH=12, `wen` to addr 13 data 99 -> no word changes, `oob_err`=1 next edge and stays 1; raddr 14 -> `rdata`=0.
- Reset mid-clear: assert `rst` at clr_ptr=5 -> `ready`=0, outputs 0; after release full 16-cycle sweep repeats.
